dsp48a1_mac_ctrl: RTL

Sequencer for one DSP48A1-style multiply-accumulate slice whose A/B, M and P registers are clock-enable gated pipeline registers with a sync/async reset option. The block accepts a command of N operand pairs and gates the upstream operand stream with a valid/ready handshake. It drives the slice CE, P-reset and OPMODE controls so that each product lands in P exactly once. It then holds P stable and presents it as a result with a valid/ready handshake.

---
 rtl/dsp48a1_pkg.sv | 22 ++
 rtl/dsp48a1_mac_ctrl_if.sv | 32 +++
 rtl/dsp48a1_mac_ctrl_tag_pipe.sv | 33 +++
 rtl/dsp48a1_mac_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
package dsp48a1_pkg;

    localparam logic [7:0] OPM_MULT = 8'h01;   // X=M, Z=0
    localparam logic [7:0] OPM_MAC  = 8'h09;   // X=M, Z=P

    localparam int PIPE_LAT_MIN = 3;
    localparam int PIPE_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

    typedef struct packed {
        logic valid;
        logic first;
    } tag_t;

endpackage

// File: rtl/dsp48a1_mac_ctrl_if.sv
// Command, operand, slice-control and result signals of the MAC sequencer.
interface dsp48a1_mac_ctrl_if #(
    parameter int LEN_W    = 8,
    parameter int OPMODE_W = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [LEN_W-1:0]    cmd_len;
    logic                cmd_acc;
    logic                op_valid;
    logic                op_ready;
    logic                dsp_ce_ab;
    logic                dsp_ce_m;
    logic                dsp_ce_p;
    logic                dsp_rst_p;
    logic [OPMODE_W-1:0] dsp_opmode;
    logic                res_valid;
    logic                res_ready;
    logic                busy;

    modport master (
        input  cmd_valid, cmd_len, cmd_acc, op_valid, res_ready,
        output cmd_ready, op_ready, dsp_ce_ab, dsp_ce_m, dsp_ce_p,
               dsp_rst_p, dsp_opmode, res_valid, busy
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_acc, op_valid, res_ready,
        input  cmd_ready, op_ready, dsp_ce_ab, dsp_ce_m, dsp_ce_p,
               dsp_rst_p, dsp_opmode, res_valid, busy
    );
endinterface

// File: rtl/dsp48a1_mac_ctrl_tag_pipe.sv
// Token shift register that tracks each accepted operand pair through the slice pipeline.
module mac_tag_pipe
    import dsp48a1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_first,
    output logic [DEPTH-1:0] valid_vec,
    output logic             p_first
);
    tag_t [DEPTH-1:0] pipe_q, pipe_d;
    tag_t             head;

    // Shifts every cycle; an empty head is a bubble that keeps downstream CEs low.
    always_comb begin
        head.valid = push;
        head.first = push & push_first;
        pipe_d     = {pipe_q[DEPTH-2:0], head};
        valid_vec  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec[i] = pipe_q[i].valid;
        end
        p_first = pipe_q[DEPTH-1].first;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
    end
endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// Sequencer for one DSP48A1 MAC slice: gates operands, drives CE/OPMODE so each product lands in P once.
module dsp48a1_mac_ctrl
    import dsp48a1_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3,
    parameter int OPMODE_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    dsp48a1_mac_ctrl_if.master  bus
);
    localparam int PL    = (PIPE_LAT < PIPE_LAT_MIN) ? PIPE_LAT_MIN :
                           (PIPE_LAT > PIPE_LAT_MAX) ? PIPE_LAT_MAX : PIPE_LAT;
    localparam int DEPTH = PL - 1;
    localparam bit TWO_AB = (PL == 4);

    mac_state_t       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             first_q, first_d;
    logic             rst_p_q, rst_p_d;
    logic             op_ready;
    logic             accept;
    logic [DEPTH-1:0] tag_valid;
    logic             p_first;

    mac_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_first (first_q),
        .valid_vec  (tag_valid),
        .p_first    (p_first)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        first_d  = first_q;
        rst_p_d  = 1'b0;
        op_ready = (state_q == FEED) && (cnt_q != '0);
        accept   = bus.op_valid & op_ready;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cnt_d   = bus.cmd_len;
                    acc_d   = bus.cmd_acc;
                    first_d = 1'b1;
                    if (bus.cmd_len != '0) begin
                        state_d = FEED;
                    end else if (!bus.cmd_acc) begin
                        // Empty overwrite command: DRAIN finds the pipe empty and carries the P clear.
                        rst_p_d = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            FEED: begin
                if (accept) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once only the P stage can still hold a token, so HOLD follows the last ce_p.
                if (~|tag_valid[DEPTH-2:0]) state_d = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            first_q <= 1'b0;
            rst_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            rst_p_q <= rst_p_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.op_ready   = op_ready;
    assign bus.res_valid  = (state_q == HOLD);
    assign bus.dsp_rst_p  = rst_p_q;
    assign bus.dsp_ce_ab  = accept | (TWO_AB & tag_valid[0]);
    assign bus.dsp_ce_m   = tag_valid[DEPTH-2];
    assign bus.dsp_ce_p   = tag_valid[DEPTH-1];
    assign bus.dsp_opmode = !tag_valid[DEPTH-1]  ? '0 :
                            (p_first && !acc_q) ? OPMODE_W'(OPM_MULT) : OPMODE_W'(OPM_MAC);
endmodule
